// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the power-on reset sequencer.
// State encoding doubles as the debug value driven on the state port.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_CLK  = 2'd0,
        ST_MEM  = 2'd1,
        ST_PROC = 2'd2,
        ST_RUN  = 2'd3
    } seq_state_e;

    localparam int DEF_DIV_HOLD  = 16;
    localparam int DEF_MEM_HOLD  = 32;
    localparam int DEF_PROC_HOLD = 32;
    localparam int DEF_CNT_W     = 8;

    typedef struct packed {
        logic clk_reset;
        logic mem_reset;
        logic proc_reset;
        logic ready;
    } rst_vec_t;

    localparam rst_vec_t RST_ALL = rst_vec_t'(4'b1110);

    function automatic rst_vec_t decode_resets(input seq_state_e s);
        rst_vec_t v;
        v = RST_ALL;
        unique case (s)
            ST_CLK:  v = rst_vec_t'(4'b1110);
            ST_MEM:  v = rst_vec_t'(4'b0110);
            ST_PROC: v = rst_vec_t'(4'b0010);
            ST_RUN:  v = rst_vec_t'(4'b0001);
        endcase
        return v;
    endfunction

endpackage

// File: rtl/hold_counter.sv
// Free-running hold counter with clear, enable and terminal-count flag.
// terminal fires when the count reaches hold-1.
module hold_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] hold,
    output logic             terminal
);

    logic [CNT_W-1:0] count_q = '0;

    always_ff @(posedge clock) begin
        if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign terminal = (count_q == hold - CNT_W'(1));

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: clock tree, then memories, then processor core.
// All outputs come straight from flops that power up in the reset state.
import reset_seq_pkg::*;

module reset_sequencer #(
    parameter int DIV_HOLD  = DEF_DIV_HOLD,
    parameter int MEM_HOLD  = DEF_MEM_HOLD,
    parameter int PROC_HOLD = DEF_PROC_HOLD,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       soft_reset,
    output logic       clk_reset,
    output logic       mem_reset,
    output logic       proc_reset,
    output logic       ready,
    output logic [1:0] state
);

    localparam longint MAX_HOLD = (longint'(1) << CNT_W) - 1;

    if (CNT_W < 1 || CNT_W > 31) begin : g_bad_width
        $error("reset_sequencer: CNT_W out of range");
    end
    if (DIV_HOLD < 1 || DIV_HOLD > MAX_HOLD) begin : g_bad_div
        $error("reset_sequencer: DIV_HOLD out of range");
    end
    if (MEM_HOLD < 1 || MEM_HOLD > MAX_HOLD) begin : g_bad_mem
        $error("reset_sequencer: MEM_HOLD out of range");
    end
    // Two edges of the 6.25 MHz core clock need at least 16 board cycles.
    if (PROC_HOLD < 16 || PROC_HOLD > MAX_HOLD) begin : g_bad_proc
        $error("reset_sequencer: PROC_HOLD out of range");
    end

    localparam logic [CNT_W-1:0] DIV_H  = CNT_W'(DIV_HOLD);
    localparam logic [CNT_W-1:0] MEM_H  = CNT_W'(MEM_HOLD);
    localparam logic [CNT_W-1:0] PROC_H = CNT_W'(PROC_HOLD);

    seq_state_e       state_q = ST_CLK;
    seq_state_e       state_d;
    rst_vec_t         out_q   = RST_ALL;
    logic [CNT_W-1:0] hold;
    logic             terminal;
    logic             clear;
    logic             enable;

    always_comb begin
        hold = PROC_H;
        unique case (state_q)
            ST_CLK:  hold = DIV_H;
            ST_MEM:  hold = MEM_H;
            ST_PROC: hold = PROC_H;
            ST_RUN:  hold = PROC_H;
        endcase
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_CLK:  if (terminal) state_d = ST_MEM;
            ST_MEM:  if (terminal) state_d = ST_PROC;
            ST_PROC: if (terminal) state_d = ST_RUN;
            ST_RUN:  if (soft_reset) state_d = ST_PROC;
        endcase
        if (reset) state_d = ST_CLK;
    end

    // Clearing on any state change covers every entry, including soft restart.
    assign clear  = reset || (state_d != state_q);
    assign enable = (state_q != ST_RUN);

    hold_counter #(
        .CNT_W(CNT_W)
    ) u_hold (
        .clock   (clock),
        .clear   (clear),
        .enable  (enable),
        .hold    (hold),
        .terminal(terminal)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_CLK;
            out_q   <= RST_ALL;
        end else begin
            state_q <= state_d;
            out_q   <= decode_resets(state_d);
        end
    end

    assign clk_reset  = out_q.clk_reset;
    assign mem_reset  = out_q.mem_reset;
    assign proc_reset = out_q.proc_reset;
    assign ready      = out_q.ready;
    assign state      = state_q;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or asynchronous input exists.
REQ-002 Parameter DIV_HOLD, default 16: cycles clk_reset stays asserted after reset deasserts.
REQ-003 Parameter MEM_HOLD, default 32: additional cycles mem_reset stays asserted after clk_reset releases.
REQ-004 Parameter PROC_HOLD, default 32: additional cycles proc_reset stays asserted after mem_reset releases.
REQ-005 Parameter CNT_W, default 8: hold-counter width.
REQ-006 clock  input  1  50 MHz board clock, the same net that feeds the clock-divider tree.
REQ-007 reset  input  1  synchronous active-high system reset.
REQ-008 soft_reset  input  1  processor-only restart request, level-sampled.
REQ-009 clk_reset  output  1  reset to the clock-divider tree.
REQ-010 mem_reset  output  1  reset to imem/dmem/regfile logic.
REQ-011 proc_reset  output  1  reset to processor core.
REQ-012 ready  output  1  high only when all resets are released.
REQ-013 state  output  2  current FSM state, for debug.

Function
REQ-014 All outputs SHALL be registered; no combinational path SHALL exist from any input to any output.
REQ-015 The FSM SHALL have four states: ST_CLK=0, ST_MEM=1, ST_PROC=2, ST_RUN=3.
REQ-016 Resets asserted per state: ST_CLK all three; ST_MEM mem_reset and proc_reset; ST_PROC proc_reset only; ST_RUN none, with ready=1.
REQ-017 A single hold counter SHALL clear on every state entry and increment each cycle.
REQ-018 The FSM SHALL leave a state on the edge where the counter equals HOLD-1, so the state lasts exactly HOLD cycles.
REQ-019 Transition order SHALL be ST_CLK->ST_MEM->ST_PROC->ST_RUN; no state is skipped.
REQ-020 Release timing, counted from the first edge sampling reset=0: clk_reset falls at edge DIV_HOLD; mem_reset falls at edge DIV_HOLD+MEM_HOLD; proc_reset falls and ready rises at edge DIV_HOLD+MEM_HOLD+PROC_HOLD.
REQ-021 soft_reset=1 sampled in ST_RUN SHALL move the FSM to ST_PROC with the counter cleared: proc_reset=1 and ready=0 on the next edge, for PROC_HOLD cycles.
REQ-022 soft_reset SHALL be ignored in ST_CLK, ST_MEM and ST_PROC.
REQ-023 If soft_reset is still high at ST_PROC exit, the FSM SHALL enter ST_RUN, then re-enter ST_PROC on the following edge.
REQ-024 reset SHALL take priority over soft_reset.
REQ-025 A one-cycle reset pulse SHALL be sufficient to restart the full sequence.
REQ-026 The counter SHALL never wrap: each HOLD SHALL be ≤ 2^CNT_W − 1.
REQ-027 PROC_HOLD SHALL be ≥ 16 so proc_reset spans at least two 6.25 MHz processor clock edges; out-of-range parameters SHALL fail elaboration.
REQ-028 Each HOLD SHALL be ≥ 1.

Reset
REQ-029 reset=1 at any edge, in any state or mid-count, SHALL force ST_CLK, counter=0, clk_reset=mem_reset=proc_reset=1 and ready=0 on that edge.
REQ-030 Register power-up values SHALL equal the reset values, so the resets are asserted before the first reset pulse.

Structure
REQ-031 Package reset_seq_pkg SHALL hold the state encoding and the default HOLD constants.
REQ-032 One sub-module, hold_counter, SHALL be used: a CNT_W-bit counter with clear and a terminal-count output, where terminal count = counter equals a HOLD input minus 1.

Verification (defaults 16/32/32)
REQ-033 Pulse reset for 1 cycle, then hold low -> clk_reset falls at edge 16, mem_reset at edge 48, proc_reset/ready at edge 80; state steps 0,1,2,3.
REQ-034 Assert reset at edge 30 (in ST_MEM) -> all resets return to 1 on that edge; after release the 16/48/80 timing repeats.
REQ-035 In ST_RUN, 1-cycle soft_reset -> proc_reset=1 and ready=0 for exactly 32 cycles; clk_reset and mem_reset stay 0.
REQ-036 soft_reset held during ST_MEM -> no effect; release timing unchanged.
REQ-037 soft_reset held continuously in ST_RUN -> ST_PROC for 32 cycles, ST_RUN for 1 cycle, repeating.
REQ-038 reset and soft_reset both high in ST_RUN -> FSM enters ST_CLK with all three resets asserted.
